fft_out_framer: RTL and testbench
=================================

FFT_OUT_FRAMER -- requirements
Module: fft_out_framer

Interface
REQ-001 Parameter DEPTH, default 64, FIFO entry count, power of two, at least 32.
REQ-002 Parameter W, default 9, sample width per real/imag component.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream sample strobe; high for 32 consecutive cycles per frame during bank readout.
REQ-006 in_re  in  W  signed two's-complement real part, natural-order FFT output.
REQ-007 in_im  in  W  signed imaginary part.
REQ-008 out_ready  in  1  downstream accept.
REQ-009 clr_ovf  in  1  synchronous clear of the sticky overflow flag.
REQ-010 out_valid  out  1  FIFO non-empty.
REQ-011 out_re / out_im  out  W each  head-of-FIFO sample.
REQ-012 out_idx  out  5  bin index 0..31 of the head sample.
REQ-013 out_last  out  1  high when out_idx==31.
REQ-014 out_frame  out  8  count of completed frames popped, modulo 256.
REQ-015 overflow  out  1  sticky; a sample was dropped.
REQ-016 level  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 The block SHALL tag each accepted in_valid sample with a write bin index wr_idx that starts at 0 and increments modulo 32 on every in_valid cycle.
REQ-018 wr_idx SHALL advance on every in_valid cycle, including dropped samples, so frame alignment is preserved.
REQ-019 A push SHALL occur when in_valid is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 A full FIFO with in_valid high and no same-cycle pop SHALL drop the sample, leave contents unchanged, and set overflow on the next edge.
REQ-021 A pop SHALL occur exactly when out_valid and out_ready are both high.
REQ-022 Outputs SHALL be driven from registered FIFO state; a sample pushed into an empty FIFO SHALL appear on out_valid/out_re/out_im/out_idx on the next cycle (latency 1).
REQ-023 Simultaneous push and pop on a non-empty FIFO SHALL leave level unchanged.
REQ-024 out_re, out_im, out_idx and out_last SHALL read 0 whenever out_valid is low.
REQ-025 out_frame SHALL increment on each pop with out_last high, wrapping 255 to 0.
REQ-026 In-valid gaps within a frame SHALL hold wr_idx; indexing SHALL resume at the held value.
REQ-027 overflow SHALL remain set until clr_ovf is high; if clr_ovf and a new drop occur in the same cycle, the drop SHALL win and overflow SHALL stay 1.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished using an extra pointer bit.

Reset
REQ-029 While rst is high, pointers, level, wr_idx, out_frame and overflow SHALL be 0, out_valid SHALL be 0, and all data outputs SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first in_valid after release SHALL be tagged bin 0.

Configuration
REQ-031 With macro FFT_OUT_MAG_EN defined, an extra output out_mag (W+1 bits, unsigned) SHALL equal |out_re|+|out_im| of the head sample, with |-256| = 256, and SHALL be 0 when out_valid is low.
REQ-032 Without FFT_OUT_MAG_EN, port out_mag and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Shared package fft_pkg SHALL hold FFT_N=32, IDX_W=5, SAMPLE_W=9 and a packed sample typedef {idx, re, im}.
REQ-034 Storage SHALL be a sub-module fft_out_fifo (synchronous FIFO, DEPTH x packed sample); indexing, counters, overflow and magnitude logic stay in the top level.

Verification
REQ-035 Reset, then one frame of in_re=k, in_im=-k for k=0..31 with out_ready=1 -> 32 outputs in order, out_idx=k, out_last only at k=31, out_frame 0->1.
REQ-036 out_ready=0, three frames pushed with DEPTH=64 -> level saturates at 64, overflow=1, frame-3 samples dropped; after draining, 64 samples with idx 0..31 twice.
REQ-037 Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> push accepted, level stays 64, overflow stays 0.
REQ-038 rst pulsed after 10 samples of a frame -> out_valid=0 and level=0 immediately; the next in_valid sample emerges with out_idx=0.
REQ-039 FFT_OUT_MAG_EN build with in_re=-256, in_im=255 -> out_mag=511; in_re=0, in_im=0 -> out_mag=0.
REQ-040 overflow set, clr_ovf pulsed with no drop -> overflow=0 next cycle; clr_ovf coincident with a drop -> overflow stays 1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and the packed sample layout for the FFT output framer path.
package fft_pkg;

  localparam int FFT_N    = 32;
  localparam int IDX_W    = 5;
  localparam int SAMPLE_W = 9;

  typedef struct packed {
    logic        [IDX_W-1:0]    idx;
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } sample_t;

endpackage

// File: rtl/fft_out_fifo.sv
// Synchronous FIFO with first-word fall-through from registered state; head data is
// the entry at the read pointer, so a push into an empty FIFO is visible one cycle later.
module fft_out_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DW    = IDX_W + 2 * SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // The extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fft_out_framer.sv
// Tags natural-order FFT bins with a bin index, buffers them for a ready/valid sink and
// counts frames. Defining FFT_OUT_MAG_EN adds an |re|+|im| magnitude output, out_mag.
module fft_out_framer
  import fft_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [W-1:0]    in_re,
  input  logic signed [W-1:0]    in_im,
  input  logic                   out_ready,
  input  logic                   clr_ovf,
  output logic                   out_valid,
  output logic signed [W-1:0]    out_re,
  output logic signed [W-1:0]    out_im,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic [7:0]             out_frame,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
`ifdef FFT_OUT_MAG_EN
  ,
  output logic [W:0]             out_mag
`endif
);

  typedef struct packed {
    logic        [IDX_W-1:0] idx;
    logic signed [W-1:0]     re;
    logic signed [W-1:0]     im;
  } entry_t;

  entry_t           w_wr_entry;
  entry_t           w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [IDX_W-1:0] r_wr_idx;
  logic [7:0]       r_frame;
  logic             r_ovf;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = in_valid && (!w_full || w_pop);
  assign w_drop     = in_valid && w_full && !w_pop;
  assign w_wr_entry = '{idx: r_wr_idx, re: in_re, im: in_im};

  fft_out_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wr_entry),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (level)
  );

  // Bin index advances on dropped samples too, keeping later frames aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx <= '0;
      r_frame  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (in_valid) r_wr_idx <= r_wr_idx + IDX_W'(1);
      if (w_pop && (w_head.idx == IDX_W'(FFT_N - 1))) r_frame <= r_frame + 8'd1;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign out_valid = !w_empty;
  assign out_re    = out_valid ? w_head.re  : '0;
  assign out_im    = out_valid ? w_head.im  : '0;
  assign out_idx   = out_valid ? w_head.idx : '0;
  assign out_last  = out_valid && (w_head.idx == IDX_W'(FFT_N - 1));
  assign out_frame = r_frame;
  assign overflow  = r_ovf;

`ifdef FFT_OUT_MAG_EN
  // One extra bit so that |most-negative| is representable.
  function automatic logic [W:0] abs_ext(input logic signed [W-1:0] v);
    logic signed [W:0] ext;
    ext = (W+1)'(v);
    return ext[W] ? (W+1)'(-ext) : (W+1)'(ext);
  endfunction

  assign out_mag = out_valid ? (abs_ext(w_head.re) + abs_ext(w_head.im)) : '0;
`endif

endmodule

// File: tb/tb_fft_out_framer.sv
// Scoreboard bench for fft_out_framer: a queue-level model predicts accepted samples,
// occupancy, frame count and overflow; a negedge monitor compares the DUT against it.
module tb_fft_out_framer;

  localparam int DEPTH = 64;
  localparam int W     = 9;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                out_ready = 1'b0;
  logic                clr_ovf = 1'b0;
  logic                out_valid;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic [4:0]          out_idx;
  logic                out_last;
  logic [7:0]          out_frame;
  logic                overflow;
  logic [LW-1:0]       level;
`ifdef FFT_OUT_MAG_EN
  logic [W:0]          out_mag;
`endif

  fft_out_framer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_frame (out_frame),
    .overflow  (overflow),
    .level     (level)
`ifdef FFT_OUT_MAG_EN
    ,
    .out_mag   (out_mag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int re;
    int im;
  } ent_t;

  ent_t exp_q[$];
  int   m_q[$];
  int   m_widx;
  int   m_frame;
  int   m_ovf;
  int   rd_cnt;
  int   n_checks;
  int   n_fail;
  ent_t mon_e;
  bit   mdl_pop;
  bit   mdl_push;
  bit   mdl_full;

  // Reference model: the FIFO as a plain queue, updated at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_widx  = 0;
      m_frame = 0;
      m_ovf   = 0;
    end else begin
      mdl_pop  = (m_q.size() > 0) && out_ready;
      mdl_full = (m_q.size() == DEPTH);
      mdl_push = in_valid && (!mdl_full || mdl_pop);
      if (mdl_pop) begin
        if (m_q[0] == 31) m_frame = (m_frame + 1) % 256;
        void'(m_q.pop_front());
      end
      if (mdl_push) begin
        m_q.push_back(m_widx);
        exp_q.push_back('{m_widx, int'(in_re), int'(in_im)});
      end
      if (in_valid && mdl_full && !mdl_pop) m_ovf = 1;
      else if (clr_ovf)                    m_ovf = 0;
      if (in_valid) m_widx = (m_widx + 1) % 32;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = exp_q.size();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_frame", int'(out_frame), 0);
      chk("rst_re", int'(out_re), 0);
      chk("rst_idx", int'(out_idx), 0);
    end else begin
      chk("valid", int'(out_valid), int'(m_q.size() > 0));
      chk("level", int'(level), m_q.size());
      chk("overflow", int'(overflow), m_ovf);
      chk("frame", int'(out_frame), m_frame);
      if (out_valid) begin
        if (rd_cnt >= exp_q.size()) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          mon_e = exp_q[rd_cnt];
          chk("idx", int'(out_idx), mon_e.idx);
          chk("re", int'(out_re), mon_e.re);
          chk("im", int'(out_im), mon_e.im);
          chk("last", int'(out_last), int'(mon_e.idx == 31));
`ifdef FFT_OUT_MAG_EN
          chk("mag", int'(out_mag), iabs(mon_e.re) + iabs(mon_e.im));
`endif
        end
        if (out_ready) rd_cnt++;
      end else begin
        chk("idle_re", int'(out_re), 0);
        chk("idle_im", int'(out_im), 0);
        chk("idle_idx", int'(out_idx), 0);
        chk("idle_last", int'(out_last), 0);
`ifdef FFT_OUT_MAG_EN
        chk("idle_mag", int'(out_mag), 0);
`endif
      end
    end
  end

  task automatic step(input bit v, input int re, input int im, input bit rdy, input bit clr);
    in_valid  = v;
    in_re     = W'(re);
    in_im     = W'(im);
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  int thr[6] = '{100, 50, 10, 90, 0, 70};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rd_cnt   = 0;
    #1;
    do_reset();

    // One clean frame, consumer always ready.
    for (int k = 0; k < 32; k++) step(1, k, -k, 1, 0);
    drain(4);

    // Fill to exactly DEPTH, then push+pop while full, then drops.
    for (int k = 0; k < 64; k++) step(1, k - 20, (k * 7) - 200, 0, 0);
    step(1, 100, -100, 1, 0);
    step(1, -256, 255, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 7, 7, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 2, 2, 0, 1);
    step(0, 0, 0, 0, 0);
    drain(70);
    step(0, 0, 0, 1, 1);

    // Three frames into a stalled sink.
    for (int k = 0; k < 96; k++) step(1, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, 0, 0);
    drain(70);
    step(0, 0, 0, 1, 1);

    // Reset in the middle of a frame.
    for (int k = 0; k < 10; k++) step(1, k + 50, k - 50, 0, 0);
    do_reset();
    for (int k = 0; k < 5; k++) step(1, k + 3, -k - 3, 1, 0);
    drain(4);

    // Magnitude extremes.
    step(1, -256, 255, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 255, -256, 1, 0);
    step(1, -256, -256, 1, 0);
    step(1, -1, 1, 1, 0);
    drain(4);

    // Random traffic with in_valid gaps and varying back-pressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        step(($urandom % 10) < 8,
             int'($urandom_range(0, 511)) - 256,
             int'($urandom_range(0, 511)) - 256,
             int'($urandom % 100) < thr[ph],
             ($urandom % 40) == 0);
      end
    end
    drain(80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
